rr_mux_pipe: RTL and testbench

- Parametrised M-way, N-bit selector with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two modes: fixed select (software-chosen channel) and round-robin arbitration among valid channels.
- Sits between multiple producers (register-file read ports, peripheral data sources) and a single consumer; replaces hand-built mux trees where back-pressure and fairness are needed.

---
 rtl/rr_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/rr_mux_pipe.sv | 93 +++++++++
 tb/tb_rr_mux_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin / fixed-select channel mux.
package rr_mux_pkg;

    typedef enum logic {
        MUX_FIXED = 1'b0,
        MUX_RR    = 1'b1
    } mux_mode_t;

    // Select-field width for an m-way mux; never narrower than one bit.
    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after ptr wins,
// wrapping modulo M. ptr is expected to be below M.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int M     = 32,
    parameter int SEL_W = $clog2(M)
) (
    input  logic [M-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (latch).
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int i = 1; i <= M; i++) begin
            cand = int'(ptr) + i;
            if (cand >= M) begin
                cand = cand - M;
            end
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_mux_pipe.sv
// M-way, N-bit channel selector with fixed or round-robin grant, valid/ready
// handshakes and a single registered output stage.
module rr_mux_pipe
    import rr_mux_pkg::*;
#(
    parameter int N     = 32,
    parameter int M     = 32,
    parameter int SEL_W = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M*N-1:0]   in_data,
    input  logic [M-1:0]     in_valid,
    output logic [M-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    output logic [N-1:0]     out_data,
    output logic [SEL_W-1:0] out_channel,
    output logic             out_valid,
    input  logic             out_ready
);

    mux_mode_t        mode_e;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] rr_gnt_idx, gnt_idx;
    logic             rr_gnt_valid, fix_gnt_valid, sel_in_range, gnt_valid;
    logic             can_load, xfer;
    logic [N-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_channel_q, out_channel_d;
    logic             out_valid_q, out_valid_d;

    assign mode_e = mux_mode_t'(mode);

    rr_arbiter #(.M(M), .SEL_W(SEL_W)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_idx   (rr_gnt_idx),
        .gnt_valid (rr_gnt_valid)
    );

    // Out-of-range selects (non-power-of-two M) never index in_valid.
    assign sel_in_range  = (int'(select) < M);
    assign fix_gnt_valid = sel_in_range && in_valid[sel_in_range ? select : '0];

    assign gnt_idx   = (mode_e == MUX_RR) ? rr_gnt_idx   : select;
    assign gnt_valid = (mode_e == MUX_RR) ? rr_gnt_valid : fix_gnt_valid;
    assign can_load  = !out_valid_q || out_ready;
    assign xfer      = can_load && gnt_valid && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        rr_ptr_d      = rr_ptr_q;
        if (xfer) begin
            out_data_d    = in_data[int'(gnt_idx)*N +: N];
            out_channel_d = gnt_idx;
            out_valid_d   = 1'b1;
            if (mode_e == MUX_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            rr_ptr_q      <= SEL_W'(M - 1);
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Scoreboard bench for rr_mux_pipe: a 32-way and a 5-way instance share one
// clock; expected beats are queued at the input handshake and compared at the output.
module tb_rr_mux_pipe;
    import rr_mux_pkg::*;

    localparam int N  = 32;
    localparam int MA = 32;
    localparam int MB = 5;
    localparam int SA = sel_width(MA);
    localparam int SB = sel_width(MB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [MA*N-1:0] a_in_data   = '0;
    logic [MA-1:0]   a_in_valid  = '0;
    logic [MA-1:0]   a_in_ready;
    logic            a_mode      = 1'b0;
    logic [SA-1:0]   a_select    = '0;
    logic [N-1:0]    a_out_data;
    logic [SA-1:0]   a_out_channel;
    logic            a_out_valid;
    logic            a_out_ready = 1'b1;

    logic [MB*N-1:0] b_in_data   = '0;
    logic [MB-1:0]   b_in_valid  = '0;
    logic [MB-1:0]   b_in_ready;
    logic            b_mode      = 1'b0;
    logic [SB-1:0]   b_select    = '0;
    logic [N-1:0]    b_out_data;
    logic [SB-1:0]   b_out_channel;
    logic            b_out_valid;
    logic            b_out_ready = 1'b1;

    rr_mux_pipe #(.N(N), .M(MA)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .select(a_select),
        .out_data(a_out_data), .out_channel(a_out_channel),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    rr_mux_pipe #(.N(N), .M(MB)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .select(b_select),
        .out_data(b_out_data), .out_channel(b_out_channel),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
    } beat_t;

    beat_t       sb_a[$];
    beat_t       sb_b[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] base   = '0;
    bit          m_valid[2];
    int          m_ptr[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_a.delete();
        sb_b.delete();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_ptr[0]   = MA - 1;
        m_ptr[1]   = MB - 1;
    endtask

    // One clock cycle: drive data, check both instances against the model, advance.
    task automatic step();
        int          m, sel, g, c;
        logic [31:0] iv, ir, od, oc, exp_rdy, dbase;
        logic        md, ov, ordy;
        bit          gv, cl;
        beat_t       front;
        string       p;
        for (int i = 0; i < MA; i++) a_in_data[i*N +: N] = base + 32'(i);
        for (int i = 0; i < MB; i++) b_in_data[i*N +: N] = base + 32'h1000 + 32'(i);
        #1;
        for (int inst = 0; inst < 2; inst++) begin
            if (inst == 0) begin
                p = "a."; m = MA; iv = a_in_valid; ir = a_in_ready; md = a_mode;
                sel = int'(a_select); ov = a_out_valid; od = a_out_data;
                oc = 32'(a_out_channel); ordy = a_out_ready; dbase = base;
            end else begin
                p = "b."; m = MB; iv = 32'(b_in_valid); ir = 32'(b_in_ready); md = b_mode;
                sel = int'(b_select); ov = b_out_valid; od = b_out_data;
                oc = 32'(b_out_channel); ordy = b_out_ready; dbase = base + 32'h1000;
            end
            cl = !m_valid[inst] || ordy;
            gv = 1'b0;
            g  = 0;
            if (md == 1'b0) begin
                if (sel < m && iv[sel]) begin
                    gv = 1'b1;
                    g  = sel;
                end
            end else begin
                for (int k = 0; k < m; k++) begin
                    c = (m_ptr[inst] + 1 + k) % m;
                    if (!gv && iv[c]) begin
                        gv = 1'b1;
                        g  = c;
                    end
                end
            end
            exp_rdy = (cl && gv) ? (32'd1 << g) : 32'd0;
            check({p, "in_ready"}, ir, exp_rdy);
            check({p, "out_valid"}, 32'(ov), 32'(m_valid[inst]));
            if (m_valid[inst]) begin
                front = '{ch: -1, data: 32'hxxxxxxxx};
                if (inst == 0 && sb_a.size() > 0) front = sb_a[0];
                if (inst == 1 && sb_b.size() > 0) front = sb_b[0];
                check({p, "out_data"}, od, front.data);
                check({p, "out_channel"}, oc, 32'(front.ch));
                if (ordy) begin
                    if (inst == 0 && sb_a.size() > 0) void'(sb_a.pop_front());
                    if (inst == 1 && sb_b.size() > 0) void'(sb_b.pop_front());
                end
            end
            if (cl && gv) begin
                if (inst == 0) sb_a.push_back('{ch: g, data: dbase + 32'(g)});
                else           sb_b.push_back('{ch: g, data: dbase + 32'(g)});
                m_valid[inst] = 1'b1;
                if (md) m_ptr[inst] = g;
            end else if (ordy) begin
                m_valid[inst] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();

        // Reset values while rst is held.
        a_in_valid = '1;
        #3;
        check("rst.a.out_valid", 32'(a_out_valid), 32'd0);
        check("rst.a.out_data", a_out_data, 32'd0);
        check("rst.a.out_channel", 32'(a_out_channel), 32'd0);
        check("rst.a.in_ready", a_in_ready, 32'd0);
        check("rst.b.out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed select, channel 5, one beat per cycle.
        a_mode = 1'b0; a_select = 5; a_in_valid = '1; a_out_ready = 1'b1; base = 32'h100;
        repeat (4) step();

        // Round-robin among 3, 7, 30 with wrap back to 3.
        a_mode = 1'b1; a_in_valid = '0;
        a_in_valid[3] = 1'b1; a_in_valid[7] = 1'b1; a_in_valid[30] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            base = 32'hA000 + 32'(i * 64);
            step();
        end

        // Back-pressure on channel 2: hold four cycles, then same-cycle refill.
        a_mode = 1'b0; a_select = 2; a_in_valid = '0; a_in_valid[2] = 1'b1;
        a_out_ready = 1'b1; base = 32'hB000;
        step();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base = 32'hB100 + 32'(i * 64);
            step();
        end
        a_out_ready = 1'b1; base = 32'hC000;
        step();
        a_in_valid = '0;
        step();

        // Five-way instance: out-of-range select, then channel 4.
        b_mode = 1'b0; b_select = 3'd6; b_in_valid = 5'b11111; b_out_ready = 1'b1;
        repeat (3) step();
        b_select = 3'd4;
        repeat (2) step();

        // Mode switch: park rr_ptr on 2, run fixed on 0, resume RR at 3.
        b_mode = 1'b1; b_in_valid = 5'b00100;
        step();
        b_mode = 1'b0; b_select = 3'd0; b_in_valid = 5'b11111;
        repeat (3) step();
        b_mode = 1'b1;
        repeat (3) step();
        b_in_valid = '0;
        step();

        // Asynchronous reset with a held beat.
        a_mode = 1'b0; a_select = 0; a_in_valid = '0; a_in_valid[0] = 1'b1;
        a_out_ready = 1'b0; base = 32'hDEADBEEF;
        step();
        check("held.a.out_data", a_out_data, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        check("arst.a.out_valid", 32'(a_out_valid), 32'd0);
        check("arst.a.out_data", a_out_data, 32'd0);
        check("arst.a.out_channel", 32'(a_out_channel), 32'd0);
        check("arst.a.in_ready", a_in_ready, 32'd0);
        @(negedge clk);
        check("arst.a.in_ready_hold", a_in_ready, 32'd0);
        check("arst.a.out_valid_hold", 32'(a_out_valid), 32'd0);
        rst = 1'b0;
        model_reset();

        // After reset rr_ptr sits at M-1, so channel 0 wins first.
        a_mode = 1'b1; a_in_valid = '1; a_out_ready = 1'b1;
        b_mode = 1'b1; b_in_valid = 5'b11111; b_out_ready = 1'b1;
        base = 32'hE000;
        repeat (3) step();
        a_in_valid = '0;
        b_in_valid = '0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
